// File: rtl/detect_event_logger.sv
// Timestamps upstream detections into a small show-ahead FIFO with a saturating event count.
// Optional macro DETECT_EDGE_EN logs only the rising edge of a held detect.
module detect_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             detect_i,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [TS_W-1:0]  rd_ts_o,
    output logic [CNT_W-1:0] evt_count_o,
    output logic             full_o,
    output logic             overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             evt, empty, full, pop, push;

`ifdef DETECT_EDGE_EN
    logic det_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            det_q <= 1'b0;
        end else begin
            det_q <= detect_i;
        end
    end

    assign evt = en_i & detect_i & ~det_q;
`else
    assign evt = en_i & detect_i;
`endif

    assign empty = (occ_q == '0);
    assign full  = (occ_q == (AW+1)'(DEPTH));
    assign pop   = rd_en_i & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push  = evt & (~full | pop);

    always_comb begin
        ts_d     = ts_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (en_i) begin
            ts_d = ts_q + TS_W'(1);
        end
        if (evt && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (evt && !push) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q     <= ts_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= ts_q;
            end
        end
    end

    assign rd_valid_o  = ~empty;
    assign full_o      = full;
    assign rd_ts_o     = mem_q[rd_ptr_q];
    assign evt_count_o = cnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: doc/detect_event_logger.md
Name: detect_event_logger

Overview:
- Sits directly downstream of the non-overlapping Mealy sequence detector and consumes its `detect` output.
- Counts detections and timestamps each one against a free-running cycle counter.
- Buffers timestamps in a small show-ahead FIFO for a host or debug reader.
- Flags lost events when the FIFO overflows.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of each logged entry.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating total-detection counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  logging enable; gates the timestamp counter and event capture.
- detect  input  1  detection output from the upstream Mealy detector.
- rd_en  input  1  pop request for the FIFO head.
- rd_valid  output  1  FIFO non-empty; rd_ts holds valid data.
- rd_ts  output  TS_W  timestamp at the FIFO head (show-ahead).
- evt_count  output  CNT_W  total accepted-or-dropped detections, saturating.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; at least one event was dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - ts counter = 0, evt_count = 0, overflow = 0.
  - Read and write pointers = 0, occupancy = 0.
  - rd_valid = 0, full = 0, rd_ts = 0.
  - Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.
- Timestamp:
  - ts increments by 1 each clk edge while en = 1.
  - Wraps from 2^TS_W-1 to 0; holds while en = 0.
- Event qualification: evt = en & detect (see Optional Feature for the edge-qualified variant).
- On a clk edge with evt = 1:
  - Push the current ts value (the value before this edge's increment) into the FIFO.
  - evt_count increments by 1 and saturates at 2^CNT_W-1; no wrap.
  - A dropped event still counts in evt_count.
- Pop:
  - On a clk edge with rd_en = 1 and rd_valid = 1, the head is removed.
  - rd_en while empty is ignored; no pointer movement, no error flag.
- Full, no pop: push is dropped, the FIFO is unchanged, and overflow is set on that edge.
  - overflow stays 1 until reset.
- Full with simultaneous push and pop: both succeed; occupancy stays DEPTH; no overflow.
- Empty with simultaneous push and pop: the pop is ignored and the push succeeds; occupancy becomes 1.
- Read data:
  - rd_ts is the registered head entry, driven combinationally from the storage array.
  - A newly pushed entry is visible one cycle after the push edge (latency 1); there is no write-through.
- Flags:
  - rd_valid = (occupancy != 0); full = (occupancy == DEPTH).
  - Both are derived from registered occupancy and update on the same edge as the push or pop.
- Pointers: log2(DEPTH) bits, wrap naturally; occupancy counter is log2(DEPTH)+1 bits.
- en = 0 blocks capture but does not block pops.

Optional Feature:
- Macro: DETECT_EDGE_EN.
- Defined:
  - A registered copy det_q of detect is kept; det_q resets to 0.
  - evt = en & detect & ~det_q, so a detect held high for N cycles logs one event, on its rising edge only.
- Undefined:
  - evt = en & detect; every cycle detect is high logs an event.
  - No det_q register exists.

Test Plan:
- Reset at t=0, then en=1 with single-cycle detect pulses at ts=3 and ts=7, no reads -> FIFO holds 3 then 7; rd_valid=1; rd_ts=3; evt_count=2; overflow=0.
- 5 detect pulses with DEPTH=4 and no reads -> full=1 after the 4th; the 5th is dropped; overflow=1; evt_count=5; popping 4 times returns the first 4 timestamps in order, after which rd_valid=0.
- FIFO full, detect=1 and rd_en=1 on the same edge -> occupancy stays 4; the head advances; the new timestamp lands at the tail; overflow stays 0.
- rd_en=1 while empty, then detect -> no underflow; rd_valid rises 1 cycle after the detect edge with the correct ts.
- en=0 for 5 cycles with detect pulsing -> ts frozen; no pushes; evt_count unchanged; a pop during en=0 still works.
- Reset asserted asynchronously mid-stream with 3 entries buffered -> rd_valid, full, overflow, evt_count and rd_ts are 0 before the next clk edge.
- With DETECT_EDGE_EN: detect held high 4 cycles -> exactly 1 entry and evt_count=1.
- Without DETECT_EDGE_EN: detect held high 4 cycles -> 4 entries and evt_count=4.
